demux2_reg: RTL and testbench

DEMUX2_REG -- requirements
Module: demux2_reg

---
 rtl/demux2_reg.sv | 123 ++++++++++++
 tb/tb_demux2_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux2_reg.sv
// demux2_reg: routes each accepted word to one of two single-entry registered ports (a/b).
// Optional per-port accepted-word counters are compiled in with macro DEMUX2_COUNT_EN.
module demux2_reg #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    input  logic         s,
    output logic         a_valid,
    input  logic         a_ready,
    output logic [n-1:0] a,
`ifdef DEMUX2_COUNT_EN
    output logic [15:0]  cnt_a,
    output logic [15:0]  cnt_b,
`endif
    output logic         b_valid,
    input  logic         b_ready,
    output logic [n-1:0] b
);

    logic         a_valid_r;
    logic         b_valid_r;
    logic [n-1:0] a_data_r;
    logic [n-1:0] b_data_r;

    logic         in_ready_s;
    logic         transfer_s;
    logic         load_a_s;
    logic         load_b_s;
    logic         drain_a_s;
    logic         drain_b_s;
    logic         a_valid_next_s;
    logic         b_valid_next_s;
    logic [n-1:0] a_data_next_s;
    logic [n-1:0] b_data_next_s;

    // Handshake decode: readiness follows only the port chosen by s, never in_valid.
    always_comb begin
        in_ready_s = 1'b0;
        if (s == 1'b0) begin
            in_ready_s = (~a_valid_r) | a_ready;
        end else begin
            in_ready_s = (~b_valid_r) | b_ready;
        end
        transfer_s = in_valid & in_ready_s;
        load_a_s   = transfer_s & ~s;
        load_b_s   = transfer_s & s;
        drain_a_s  = a_valid_r & a_ready;
        drain_b_s  = b_valid_r & b_ready;
    end

    // Next-state for both entries; a refill takes priority over a drain of the same port.
    always_comb begin
        a_valid_next_s = a_valid_r;
        b_valid_next_s = b_valid_r;
        a_data_next_s  = a_data_r;
        b_data_next_s  = b_data_r;
        if (load_a_s) begin
            a_valid_next_s = 1'b1;
            a_data_next_s  = in_data;
        end else if (drain_a_s) begin
            a_valid_next_s = 1'b0;
        end else begin
            a_valid_next_s = a_valid_r;
        end
        if (load_b_s) begin
            b_valid_next_s = 1'b1;
            b_data_next_s  = in_data;
        end else if (drain_b_s) begin
            b_valid_next_s = 1'b0;
        end else begin
            b_valid_next_s = b_valid_r;
        end
    end

    // Entry registers; reset discards held words and clears data.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_r <= 1'b0;
            b_valid_r <= 1'b0;
            a_data_r  <= {n{1'b0}};
            b_data_r  <= {n{1'b0}};
        end else begin
            a_valid_r <= a_valid_next_s;
            b_valid_r <= b_valid_next_s;
            a_data_r  <= a_data_next_s;
            b_data_r  <= b_data_next_s;
        end
    end

`ifdef DEMUX2_COUNT_EN
    logic [15:0] cnt_a_r;
    logic [15:0] cnt_b_r;

    // Accepted-word counters, free-running with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_a_r <= 16'h0000;
            cnt_b_r <= 16'h0000;
        end else begin
            if (load_a_s) begin
                cnt_a_r <= cnt_a_r + 16'h0001;
            end
            if (load_b_s) begin
                cnt_b_r <= cnt_b_r + 16'h0001;
            end
        end
    end

    assign cnt_a = cnt_a_r;
    assign cnt_b = cnt_b_r;
`endif

    assign in_ready = in_ready_s;
    assign a_valid  = a_valid_r;
    assign b_valid  = b_valid_r;
    assign a        = a_data_r;
    assign b        = b_data_r;

endmodule

// File: tb/tb_demux2_reg.sv
// Self-checking bench for demux2_reg: slot-level reference model, directed scenarios
// with literal expectations, then randomized traffic with resets.
module tb_demux2_reg;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        s;
    logic        a_valid;
    logic        a_ready;
    logic [15:0] a;
    logic        b_valid;
    logic        b_ready;
    logic [15:0] b;
`ifdef DEMUX2_COUNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    int n_checks;
    int n_fail;

    // Reference model: each port is a one-word slot; counters are plain integers.
    bit          m_known;
    bit          m_af;
    bit          m_bf;
    logic [15:0] m_ad;
    logic [15:0] m_bd;
    int          m_ca;
    int          m_cb;

    demux2_reg #(.n(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .s        (s),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a        (a),
`ifdef DEMUX2_COUNT_EN
        .cnt_a    (cnt_a),
        .cnt_b    (cnt_b),
`endif
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b        (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, compare against the model, then advance the model.
    task automatic cyc(input logic rst, input logic iv, input logic sv,
                       input logic [15:0] d, input logic ar, input logic br);
        bit exp_ir;
        @(negedge clk);
        reset = rst; in_valid = iv; s = sv; in_data = d; a_ready = ar; b_ready = br;
        #1;
        exp_ir = sv ? (!m_bf || br) : (!m_af || ar);
        if (m_known) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
            chk("a_valid",  {31'd0, a_valid},  {31'd0, m_af});
            chk("b_valid",  {31'd0, b_valid},  {31'd0, m_bf});
            chk("a_data",   {16'd0, a},        {16'd0, m_ad});
            chk("b_data",   {16'd0, b},        {16'd0, m_bd});
`ifdef DEMUX2_COUNT_EN
            chk("cnt_a", {16'd0, cnt_a}, m_ca % 65536);
            chk("cnt_b", {16'd0, cnt_b}, m_cb % 65536);
`endif
        end
        @(posedge clk);
        if (rst) begin
            m_af = 1'b0; m_bf = 1'b0; m_ad = 16'h0000; m_bd = 16'h0000;
            m_ca = 0; m_cb = 0; m_known = 1'b1;
        end else begin
            if (m_af && ar) m_af = 1'b0;
            if (m_bf && br) m_bf = 1'b0;
            if (iv && exp_ir) begin
                if (sv == 1'b0) begin m_af = 1'b1; m_ad = d; m_ca++; end
                else            begin m_bf = 1'b1; m_bd = d; m_cb++; end
            end
        end
        #1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; m_known = 1'b0;
        m_af = 1'b0; m_bf = 1'b0; m_ad = 16'h0000; m_bd = 16'h0000; m_ca = 0; m_cb = 0;
        reset = 1'b1; in_valid = 1'b0; s = 1'b0; in_data = 16'h0000;
        a_ready = 1'b0; b_ready = 1'b0;

        // Reset with in_valid high: nothing may be captured.
        cyc(1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 16'hCAFE, 1'b1, 1'b1);
        chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("rst_a", {16'd0, a}, 32'h0000);
        chk("rst_b", {16'd0, b}, 32'h0000);
`ifdef DEMUX2_COUNT_EN
        chk("rst_cnt_a", {16'd0, cnt_a}, 32'd0);
        chk("rst_cnt_b", {16'd0, cnt_b}, 32'd0);
`endif
        cyc(1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Routing.
        cyc(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        chk("route_a", {16'd0, a}, 32'hFFFF);
        chk("route_a_valid", {31'd0, a_valid}, 32'd1);
        chk("route_b_empty", {31'd0, b_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
        chk("route_b", {16'd0, b}, 32'h1234);
        chk("route_a_keep", {16'd0, a}, 32'hFFFF);
        chk("route_a_drained", {31'd0, a_valid}, 32'd0);

        // Backpressure on port a.
        cyc(1'b0, 1'b1, 1'b0, 16'hAAAA, 1'b0, 1'b1);
        chk("bp_a_first", {16'd0, a}, 32'hAAAA);
        cyc(1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 1'b1);
        chk("bp_hold_a", {16'd0, a}, 32'hAAAA);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 16'h5555, 1'b1, 1'b1);
        chk("bp_release_a", {16'd0, a}, 32'h5555);
        chk("bp_release_valid", {31'd0, a_valid}, 32'd1);

        // Independence: a full and stalled, b still accepts.
        cyc(1'b0, 1'b1, 1'b1, 16'h0F0F, 1'b0, 1'b1);
        chk("ind_b", {16'd0, b}, 32'h0F0F);
        chk("ind_a_keep", {16'd0, a}, 32'h5555);
        chk("ind_a_valid", {31'd0, a_valid}, 32'd1);

        // Streaming eight words through port a.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
            chk("stream_a", {16'd0, a}, i);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
        end

        // Reset mid-operation discards held words.
        cyc(1'b0, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 16'h1111, 1'b1, 1'b1);
        chk("midrst_a_valid", {31'd0, a_valid}, 32'd0);
        chk("midrst_b_valid", {31'd0, b_valid}, 32'd0);
        chk("midrst_b", {16'd0, b}, 32'h0000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                16'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)));
        end

`ifdef DEMUX2_COUNT_EN
        // Counter wrap: 65537 transfers to port b.
        cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 65537; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'(i), 1'b1, 1'b1);
        end
        chk("wrap_cnt_b", {16'd0, cnt_b}, 32'h0001);
        chk("wrap_cnt_a", {16'd0, cnt_a}, 32'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
